// File: rtl/free_list_ctrl_pkg.sv
// Shared sizing constants and FSM state type for the rename free-list controller.
package free_list_ctrl_pkg;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int TAG_W    = 6;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/free_list_ram.sv
// Free-tag storage: single write port, asynchronous read port, no reset.
module free_list_ram
#(
    parameter int DEPTH = free_list_ctrl_pkg::NUM_ARCH,
    parameter int TAG_W = free_list_ctrl_pkg::TAG_W,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [TAG_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [TAG_W-1:0] rdata
);

    logic [TAG_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free-list controller with speculative alloc, commit and flush recovery.
// Optional same-cycle free-to-alloc bypass when empty: define FREELIST_BYPASS_EN.
//
// state      | meaning
// ST_INIT    | seeding entry i with tag NUM_PHYS-NUM_ARCH+i, one entry per cycle
// ST_RUN     | normal alloc / free / commit / flush operation
// ST_RECOVER | one cycle after a flush; no grants
module free_list_ctrl
#(
    parameter int NUM_PHYS = free_list_ctrl_pkg::NUM_PHYS,
    parameter int NUM_ARCH = free_list_ctrl_pkg::NUM_ARCH,
    parameter int TAG_W    = free_list_ctrl_pkg::TAG_W
)(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             alloc_req,
    output logic             alloc_grant,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             commit_valid,
    input  logic             flush,
    output logic [TAG_W-1:0] free_count,
    output logic             ready,
    output logic             err
);

    import free_list_ctrl_pkg::*;

    localparam int PW = $clog2(NUM_ARCH);
    localparam logic [PW-1:0]    LAST_IDX  = PW'(NUM_ARCH - 1);
    localparam logic [TAG_W-1:0] FULL      = TAG_W'(NUM_ARCH);
    localparam logic [TAG_W-1:0] TAG_BASE  = TAG_W'(NUM_PHYS - NUM_ARCH);

    state_t state, state_nxt;

    logic [PW-1:0]    head, tail, commit_head, init_idx;
    logic [TAG_W-1:0] count;
    logic             err_q;

    logic             active, grant, bypass, overflow, free_ok;
    logic             commit_ok, commit_bad, init_free;
    logic [PW-1:0]    commit_head_nxt, outstanding;

    logic             ram_we;
    logic [PW-1:0]    ram_waddr;
    logic [TAG_W-1:0] ram_wdata, ram_rdata;

    always_comb begin
        active          = (state != ST_INIT);
        grant           = alloc_req && (state == ST_RUN) && (count != '0) && !flush;
        bypass          = 1'b0;
`ifdef FREELIST_BYPASS_EN
        bypass          = alloc_req && free_valid && (state == ST_RUN) && (count == '0) && !flush;
`endif
        overflow        = free_valid && active && (count == FULL) && !grant;
        free_ok         = free_valid && active && !bypass && !overflow;
        init_free       = free_valid && !active;
        commit_ok       = commit_valid && (commit_head != head);
        commit_bad      = commit_valid && (commit_head == head);
        commit_head_nxt = commit_head + PW'(commit_ok);
        // Allocations still speculative after this cycle's commit; a flush hands them back.
        outstanding     = head - commit_head_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    if (init_idx == LAST_IDX) state_nxt = ST_RUN;
            ST_RUN:     if (flush) state_nxt = ST_RECOVER;
            ST_RECOVER: if (!flush) state_nxt = ST_RUN;
            default:    state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            init_idx    <= '0;
            count       <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= err_q | overflow | commit_bad | init_free;
            if (state == ST_INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == LAST_IDX) begin
                    count <= FULL;
                end
            end else begin
                if (commit_ok) begin
                    commit_head <= commit_head_nxt;
                end
                if (free_ok) begin
                    tail <= tail + 1'b1;
                end
                if (flush) begin
                    head  <= commit_head_nxt;
                    count <= count + TAG_W'(free_ok) + TAG_W'(outstanding);
                end else begin
                    head  <= head + PW'(grant);
                    count <= count + TAG_W'(free_ok) - TAG_W'(grant);
                end
            end
        end
    end

    always_comb begin
        ram_we    = free_ok;
        ram_waddr = tail;
        ram_wdata = free_tag;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_idx;
            ram_wdata = TAG_BASE + TAG_W'(init_idx);
        end
    end

    free_list_ram #(
        .DEPTH (NUM_ARCH),
        .TAG_W (TAG_W),
        .AW    (PW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (head),
        .rdata (ram_rdata)
    );

    always_comb begin
        alloc_grant = grant | bypass;
        alloc_tag   = '0;
        if (bypass) begin
            alloc_tag = free_tag;
        end else if (grant) begin
            alloc_tag = ram_rdata;
        end
    end

    assign free_count = count;
    assign ready      = (state == ST_RUN);
    assign err        = err_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Bench for free_list_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_free_list_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_grant;
    logic [5:0] alloc_tag;
    logic       free_valid = 1'b0;
    logic [5:0] free_tag = '0;
    logic       commit_valid = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] free_count;
    logic       ready;
    logic       err;

    always #5 CLK = ~CLK;

    free_list_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_tag    (alloc_tag),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .commit_valid (commit_valid),
        .flush        (flush),
        .free_count   (free_count),
        .ready        (ready),
        .err          (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: available tags in handout order, speculative allocations oldest first.
    int avail[$];
    int spec[$];
    int m_mode;     // 0 = seeding, 1 = running, 2 = recovering
    int init_cnt;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit req, input bit fv, input int ft, input bit cv, input bit fl);
        bit g;
        bit byp;
        int etag;
        @(negedge CLK);
        alloc_req    = req;
        free_valid   = fv;
        free_tag     = 6'(ft);
        commit_valid = cv;
        flush        = fl;
        #1;
        g   = req && (m_mode == 1) && !fl && (avail.size() != 0);
        byp = 1'b0;
`ifdef FREELIST_BYPASS_EN
        byp = req && fv && (m_mode == 1) && !fl && (avail.size() == 0);
`endif
        etag = byp ? ft : (g ? avail[0] : 0);
        check("grant", 32'(alloc_grant), 32'(g || byp));
        check("tag", 32'(alloc_tag), etag);
        check("count", 32'(free_count), avail.size());
        check("ready", 32'(ready), 32'(m_mode == 1));
        check("err", 32'(err), 32'(m_err));
        @(posedge CLK);
        if (m_mode == 0) begin
            if (fv || cv) m_err = 1'b1;
            init_cnt++;
            if (init_cnt == 32) begin
                m_mode = 1;
                avail.delete();
                for (int i = 0; i < 32; i++) avail.push_back(32 + i);
            end
        end else begin
            if (cv) begin
                if (spec.size() == 0) m_err = 1'b1;
                else void'(spec.pop_front());
            end
            if (g) spec.push_back(avail.pop_front());
            if (fv && !byp) begin
                if (avail.size() == 32 && !g) m_err = 1'b1;
                else avail.push_back(ft);
            end
            if (fl) begin
                while (spec.size() > 0) avail.push_front(spec.pop_back());
                m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        alloc_req = 1'b1;
        RESET     = 1'b0;
        #1;
        check("rst_grant", 32'(alloc_grant), 0);
        check("rst_tag", 32'(alloc_tag), 0);
        check("rst_count", 32'(free_count), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_err", 32'(err), 0);
        alloc_req = 1'b0; free_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RESET    = 1'b1;
        m_mode   = 0;
        init_cnt = 0;
        m_err    = 1'b0;
        avail.delete();
        spec.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Seeding, then drain all 32 tags in order while committing each previous one.
        do_reset();
        idle(32);
        step(1, 0, 0, 0, 0);
        for (int k = 1; k < 32; k++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        // Empty list with alloc and free of tag 7 in the same cycle.
        step(1, 1, 7, 0, 0);
        idle(1);
        // Refill, allocate 5, commit 2, flush, then recover.
        for (int i = 0; i < 10; i++) step(0, 1, 40 + i, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);

        // Overflow free at full list, sticky until reset.
        do_reset();
        idle(32);
        step(0, 1, 5, 0, 0);
        idle(3);
        // Commit with nothing outstanding.
        do_reset();
        idle(32);
        step(0, 0, 0, 1, 0);
        idle(2);
        // Free during seeding is ignored and flags an error.
        do_reset();
        idle(4);
        step(0, 1, 3, 0, 0);
        idle(28);
        step(1, 0, 0, 0, 0);

        // Reset in the middle of operation, then a clean rerun.
        do_reset();
        idle(32);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        do_reset();
        idle(32);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);

        // Random traffic, constrained so the free path never overruns speculative entries.
        do_reset();
        idle(32);
        for (int n = 0; n < 3000; n++) begin
            bit r, f, c, x;
            int t;
            r = ($urandom_range(0, 3) != 0) && (spec.size() < 31);
            f = ((avail.size() + spec.size()) < 32) && ($urandom_range(0, 2) == 0);
            c = (spec.size() > 0) && ($urandom_range(0, 2) == 0);
            x = ($urandom_range(0, 24) == 0);
            t = int'($urandom_range(0, 63));
            step(r, f, t, c, x);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/free_list_ctrl.md
FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 SHALL have parameters: NUM_PHYS, default 64, physical register count; NUM_ARCH, default 32, architectural register count; TAG_W, default 6, tag width.
REQ-002 SHALL have ports (clock and reset first):
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename stage requests one destination tag.
- alloc_grant  out  1  request accepted this cycle.
- alloc_tag  out  TAG_W  granted tag.
- free_valid  in  1  retirement returns a superseded tag.
- free_tag  in  TAG_W  returned tag.
- commit_valid  in  1  oldest speculative allocation is committed.
- flush  in  1  mispredict/syscall recovery.
- free_count  out  TAG_W  free entries (0..NUM_ARCH).
- ready  out  1  block is in RUN state.
- err  out  1  sticky error: overflow or commit underflow.

Function
REQ-003 SHALL hold free tags in a NUM_ARCH-entry circular buffer with 5-bit head (alloc), tail (free) and commit_head pointers; all pointers wrap modulo NUM_ARCH.
REQ-004 SHALL implement states INIT, RUN, RECOVER.
REQ-005 INIT: writes tag NUM_ARCH+i into entry i on cycle i, for i = 0..31; after the write of entry 31 it goes to RUN with count=32, head=commit_head=tail=0.
REQ-006 alloc_grant SHALL be combinational: alloc_req AND state==RUN AND count!=0; alloc_tag = entry[head], and is 0 when not granted.
REQ-007 On grant, head increments and count decrements at the next CLK edge (zero-cycle grant, one-cycle update).
REQ-008 On free_valid in RUN or RECOVER, free_tag is written to entry[tail], tail increments and count increments; free_valid in INIT is ignored and sets err.
REQ-009 Simultaneous grant and free: count unchanged, both pointers advance; a free while count==0 and no grant never bypasses to alloc_tag in the same cycle unless REQ-016 applies.
REQ-010 free_valid with count==32 and no simultaneous grant: write dropped, err set.
REQ-011 commit_valid increments commit_head; commit_valid when commit_head==head (no outstanding speculative allocation) is ignored and sets err.
REQ-012 flush in RUN: head <= commit_head (after applying any same-cycle commit_valid); count <= count + outstanding speculative allocations; any same-cycle grant is suppressed; state goes to RECOVER.
REQ-013 RECOVER lasts exactly one cycle with alloc_grant forced 0, then returns to RUN; flush in RECOVER re-applies REQ-012 and remains in RECOVER.
REQ-014 free_count = count; ready = (state==RUN).

Reset
REQ-015 RESET low SHALL asynchronously force state=INIT, pointers=0, count=0, INIT index=0, err=0, alloc_grant=0, free_count=0, ready=0; reset asserted mid-operation discards all contents, and INIT reruns after release.

Configuration
REQ-016 With FREELIST_BYPASS_EN defined: when count==0, state==RUN, alloc_req and free_valid are all asserted, alloc_grant=1 and alloc_tag=free_tag, with no buffer write and no change to pointers or count except head/tail staying aligned. Without FREELIST_BYPASS_EN: alloc_grant=0 in that case and the free is written normally.

Structure
REQ-017 The shared package SHALL hold TAG_W, NUM_PHYS, NUM_ARCH and the state enum (INIT/RUN/RECOVER).
REQ-018 The storage array SHALL be one sub-module, free_list_ram: 32 x TAG_W, one write port, one asynchronous read port, no reset. Pointers, count and the FSM live in the top level.

Verification
REQ-019 Scenarios:
- Reset release -> ready=0 for 32 cycles, then ready=1 and free_count=32; first grant returns tag 32.
- 32 consecutive alloc_req -> tags 32..63 in order, then alloc_grant=0 and free_count=0.
- Allocate 5 tags, commit 2, flush -> next grant returns the third tag originally issued; free_count rises by 3; alloc_grant=0 for the flush cycle and the RECOVER cycle.
- free_count=0 with alloc_req and free_valid(tag 7) in the same cycle -> alloc_grant=1, alloc_tag=7 with FREELIST_BYPASS_EN; alloc_grant=0 and free_count=1 without it.
- free_valid at free_count=32 -> err=1 and stays 1 until RESET; commit_valid with nothing outstanding -> err=1.
- RESET asserted after 10 allocations -> all outputs return to reset values immediately; INIT reruns and the first grant is tag 32.
